// File: rtl/seq_feeder_pkg.sv
// Shared definitions for the sequence feeder: score width, default depth and FSM encoding.
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

package seq_feeder_pkg;

    localparam int unsigned VEFBit    = `V_E_F_Bit;
    localparam int unsigned DefW      = VEFBit;
    localparam int unsigned DefTDepth = 256;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/seq_feeder_bram.sv
// Boundary buffer: 1R1W register array with combinational read and registered write.
module seq_feeder_bram #(
    parameter int unsigned Depth = 256,
    parameter int unsigned Width = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [Width-1:0]         rdata_o
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/seq_feeder.sv
// Streams a loaded target sequence into a systolic array head once per query pass and
// recirculates the array-tail column through a boundary buffer between passes.
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module seq_feeder
    import seq_feeder_pkg::*;
#(
    parameter int unsigned T_DEPTH = DefTDepth,
    parameter int unsigned ARRAY_N = 8,
    parameter int unsigned W       = `V_E_F_Bit
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(T_DEPTH):0] t_len,
    input  logic [7:0]               n_pass,
    input  logic [ARRAY_N-1:0]       last_mask,
    input  logic [W-1:0]             minusAlpha,
    input  logic                     in_valid,
    input  logic [1:0]               in_t,
    output logic                     in_ready,
    output logic [ARRAY_N-1:0]       arr_en,
    output logic                     arr_newLine,
    output logic [1:0]               arr_t,
    output logic [W-1:0]             arr_v,
    output logic [W-1:0]             arr_v_alpha,
    output logic [W-1:0]             arr_f,
    input  logic                     tail_valid,
    input  logic [W-1:0]             tail_v,
    input  logic [W-1:0]             tail_f,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned AW = $clog2(T_DEPTH);
    localparam int unsigned IW = AW + 1;

    state_e state_q, state_d;

    logic [IW-1:0]      t_len_q, t_len_d;
    logic [7:0]         n_pass_q, n_pass_d;
    logic [ARRAY_N-1:0] mask_q, mask_d;
    logic [IW-1:0]      ld_idx_q, ld_idx_d;
    logic [IW-1:0]      rd_idx_q, rd_idx_d;
    logic [IW-1:0]      wr_idx_q, wr_idx_d;
    logic [7:0]         pass_q, pass_d;

    logic [ARRAY_N-1:0] arr_en_q, arr_en_d;
    logic               arr_newline_q, arr_newline_d;
    logic [1:0]         arr_t_q, arr_t_d;
    logic [W-1:0]       arr_v_q, arr_v_d;
    logic [W-1:0]       arr_v_alpha_q, arr_v_alpha_d;
    logic [W-1:0]       arr_f_q, arr_f_d;

    logic [1:0]         sym_mem [T_DEPTH];
    logic [2*W-1:0]     bnd_rdata;

    logic               load_we;
    logic               tail_we;
    logic [IW-1:0]      wr_filled;
    logic               run_last;
    logic               drain_exit;
    logic               last_pass;

    assign load_we    = (state_q == StLoad) && in_valid;
    // Tail beats only count while the array can be producing them, and never past t_len.
    assign tail_we    = ((state_q == StRun) || (state_q == StDrain)) && tail_valid &&
                        (wr_idx_q < t_len_q);
    assign wr_filled  = wr_idx_q + IW'(tail_we);
    assign run_last   = (state_q == StRun) && (rd_idx_q == t_len_q - IW'(1));
    // Exit counts the beat arriving this cycle so the final tail beat costs no extra cycle.
    assign drain_exit = (state_q == StDrain) && (wr_filled == t_len_q);
    assign last_pass  = (pass_q + 8'd1 == n_pass_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (t_len == '0) ? StDone : StLoad;
            StLoad:  if (load_we && (ld_idx_q + IW'(1) == t_len_q)) state_d = StRun;
            StRun:   if (run_last) state_d = StDrain;
            StDrain: if (drain_exit) state_d = last_pass ? StDone : StRun;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StLoad);
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
    end

    always_comb begin
        t_len_d  = t_len_q;
        n_pass_d = n_pass_q;
        mask_d   = mask_q;
        ld_idx_d = ld_idx_q;
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        pass_d   = pass_q;
        if ((state_q == StIdle) && start) begin
            t_len_d  = t_len;
            n_pass_d = (n_pass == 8'd0) ? 8'd1 : n_pass;
            mask_d   = last_mask;
            ld_idx_d = '0;
            rd_idx_d = '0;
            wr_idx_d = '0;
            pass_d   = '0;
        end
        if (load_we) ld_idx_d = ld_idx_q + IW'(1);
        if (state_q == StRun) rd_idx_d = run_last ? '0 : rd_idx_q + IW'(1);
        if (tail_we) wr_idx_d = wr_filled;
        if (drain_exit) begin
            wr_idx_d = '0;
            pass_d   = pass_q + 8'd1;
        end
    end

    always_comb begin
        arr_en_d      = '0;
        arr_newline_d = 1'b0;
        arr_t_d       = '0;
        arr_v_d       = '0;
        arr_v_alpha_d = '0;
        arr_f_d       = '0;
        if (state_q == StRun) begin
            arr_en_d      = last_pass ? mask_q : '1;
            arr_newline_d = (rd_idx_q == '0);
            arr_t_d       = sym_mem[rd_idx_q[AW-1:0]];
            if (pass_q != 8'd0) begin
                arr_v_d = bnd_rdata[2*W-1:W];
                arr_f_d = bnd_rdata[W-1:0];
            end
            arr_v_alpha_d = arr_v_d + minusAlpha;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_len_q       <= '0;
            n_pass_q      <= '0;
            mask_q        <= '0;
            ld_idx_q      <= '0;
            rd_idx_q      <= '0;
            wr_idx_q      <= '0;
            pass_q        <= '0;
            arr_en_q      <= '0;
            arr_newline_q <= 1'b0;
            arr_t_q       <= '0;
            arr_v_q       <= '0;
            arr_v_alpha_q <= '0;
            arr_f_q       <= '0;
        end else begin
            t_len_q       <= t_len_d;
            n_pass_q      <= n_pass_d;
            mask_q        <= mask_d;
            ld_idx_q      <= ld_idx_d;
            rd_idx_q      <= rd_idx_d;
            wr_idx_q      <= wr_idx_d;
            pass_q        <= pass_d;
            arr_en_q      <= arr_en_d;
            arr_newline_q <= arr_newline_d;
            arr_t_q       <= arr_t_d;
            arr_v_q       <= arr_v_d;
            arr_v_alpha_q <= arr_v_alpha_d;
            arr_f_q       <= arr_f_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_we) begin
            sym_mem[ld_idx_q[AW-1:0]] <= in_t;
        end
    end

    seq_feeder_bram #(
        .Depth (T_DEPTH),
        .Width (2 * W)
    ) u_bnd_buf (
        .clk_i   (clk),
        .we_i    (tail_we),
        .waddr_i (wr_idx_q[AW-1:0]),
        .wdata_i ({tail_v, tail_f}),
        .raddr_i (rd_idx_q[AW-1:0]),
        .rdata_o (bnd_rdata)
    );

    assign arr_en      = arr_en_q;
    assign arr_newLine = arr_newline_q;
    assign arr_t       = arr_t_q;
    assign arr_v       = arr_v_q;
    assign arr_v_alpha = arr_v_alpha_q;
    assign arr_f       = arr_f_q;

endmodule

// File: tb/tb_seq_feeder.sv
// Bench for seq_feeder: a job-level model predicts every head beat, status bit and done cycle.
module tb_seq_feeder;

    localparam int unsigned TDepth = 256;
    localparam int unsigned ArrayN = 8;
    localparam int unsigned Wd     = 16;
    localparam int unsigned LW     = $clog2(TDepth) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LW-1:0]     t_len;
    logic [7:0]        n_pass;
    logic [ArrayN-1:0] last_mask;
    logic [Wd-1:0]     minusAlpha;
    logic              in_valid;
    logic [1:0]        in_t;
    logic              in_ready;
    logic [ArrayN-1:0] arr_en;
    logic              arr_newLine;
    logic [1:0]        arr_t;
    logic [Wd-1:0]     arr_v;
    logic [Wd-1:0]     arr_v_alpha;
    logic [Wd-1:0]     arr_f;
    logic              tail_valid;
    logic [Wd-1:0]     tail_v;
    logic [Wd-1:0]     tail_f;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [1:0]    sym    [TDepth];
    logic [Wd-1:0] prev_v [TDepth];
    logic [Wd-1:0] prev_f [TDepth];
    logic [Wd-1:0] cur_v  [TDepth];
    logic [Wd-1:0] cur_f  [TDepth];

    seq_feeder #(
        .T_DEPTH (TDepth),
        .ARRAY_N (ArrayN),
        .W       (Wd)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .t_len       (t_len),
        .n_pass      (n_pass),
        .last_mask   (last_mask),
        .minusAlpha  (minusAlpha),
        .in_valid    (in_valid),
        .in_t        (in_t),
        .in_ready    (in_ready),
        .arr_en      (arr_en),
        .arr_newLine (arr_newLine),
        .arr_t       (arr_t),
        .arr_v       (arr_v),
        .arr_v_alpha (arr_v_alpha),
        .arr_f       (arr_f),
        .tail_valid  (tail_valid),
        .tail_v      (tail_v),
        .tail_f      (tail_f),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One job: load, passes with tail feedback, optional mid-run reset and busy-time noise.
    task automatic run_job(input string name, input int tl, input int np,
                           input logic [ArrayN-1:0] mask, input logic [Wd-1:0] alpha,
                           input bit fixed, input bit noise, input int abort_pass);
        int npe, ld, ld_before, pass, kx, k, s, c, exp_head, exp_done;
        bit abort_now, over, timed_out, exp_ready;
        int pend_k[$];
        int pend_c[$];
        logic [ArrayN+3*Wd+2:0] obs, expv;
        logic [ArrayN-1:0] een;
        logic [Wd-1:0] ev, ef, eva, tv, tf;
        npe = (np == 0) ? 1 : np;
        for (int i = 0; i < tl; i++) sym[i] = fixed ? 2'(i % 4) : 2'($urandom_range(3));
        @(posedge clk); #1;
        s = cyc;
        start = 1'b1; t_len = LW'(tl); n_pass = 8'(np); last_mask = mask; minusAlpha = alpha;
        in_valid = 1'b0; tail_valid = 1'b0;
        ld = 0; pass = 0; kx = 0; exp_head = -1;
        exp_done = (tl == 0) ? s + 1 : -1;
        abort_now = 1'b0; over = 1'b0; timed_out = 1'b0;
        while (!over) begin
            @(posedge clk); #1;
            c = cyc;
            if (abort_now) begin
                rst = 1'b1; start = 1'b0; in_valid = 1'b0; tail_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                checks++;
                if ({in_ready, busy, done, arr_en, arr_newLine, arr_t, arr_v, arr_v_alpha,
                     arr_f} !== '0) begin
                    errors++;
                    $display("FAIL %s reset_midrun got=%h want=0", name,
                             {in_ready, busy, done, arr_en, arr_newLine, arr_t, arr_v,
                              arr_v_alpha, arr_f});
                end
                over = 1'b1;
            end else begin
                start = noise ? 1'($urandom_range(1)) : 1'b0;
                if (noise) t_len = LW'($urandom_range(TDepth));
                in_valid = 1'b0; tail_valid = 1'b0;
                ld_before = ld;
                if (ld < tl) begin
                    in_valid = ($urandom_range(3) != 0);
                    in_t = sym[ld];
                    if (in_valid) begin
                        ld++;
                        if (ld == tl) exp_head = c + 2;
                    end
                end else if (noise) begin
                    in_valid = 1'($urandom_range(1));
                    in_t = 2'($urandom_range(3));
                end
                if (pend_k.size() > 0 && pend_c[0] <= c && $urandom_range(2) != 0) begin
                    k = pend_k.pop_front();
                    void'(pend_c.pop_front());
                    tv = fixed ? Wd'(10 * (k + 1)) : Wd'($urandom);
                    tf = Wd'($urandom);
                    tail_valid = 1'b1; tail_v = tv; tail_f = tf;
                    cur_v[k] = tv; cur_f[k] = tf;
                    if (k == tl - 1) begin
                        if (pass == npe - 1) begin
                            exp_done = c + 1;
                        end else begin
                            for (int i = 0; i < tl; i++) begin
                                prev_v[i] = cur_v[i];
                                prev_f[i] = cur_f[i];
                            end
                            pass++; kx = 0; exp_head = c + 2;
                        end
                    end
                end else if (noise && (ld < tl || c == exp_done)) begin
                    // Stray beats during LOAD or DONE must not touch the run.
                    tail_valid = 1'b1;
                    tail_v = Wd'($urandom); tail_f = Wd'($urandom);
                end
                @(negedge clk);
                if (c == exp_head) begin
                    ev  = (pass == 0) ? '0 : prev_v[kx];
                    ef  = (pass == 0) ? '0 : prev_f[kx];
                    eva = ev + alpha;
                    een = (pass == npe - 1) ? mask : {ArrayN{1'b1}};
                    expv = {een, (kx == 0), sym[kx], ev, eva, ef};
                    pend_k.push_back(kx); pend_c.push_back(c + 1);
                    kx++;
                    exp_head = (kx < tl) ? c + 1 : -1;
                end else begin
                    expv = '0;
                end
                obs = {arr_en, arr_newLine, arr_t, arr_v, arr_v_alpha, arr_f};
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL %s head cyc=%0d got=%h want=%h", name, c - s, obs, expv);
                end
                exp_ready = (ld_before < tl);
                checks++;
                if ({in_ready, busy, done} !== {exp_ready, 1'b1, c == exp_done}) begin
                    errors++;
                    $display("FAIL %s status cyc=%0d ready/busy/done got=%b want=%b", name,
                             c - s, {in_ready, busy, done}, {exp_ready, 1'b1, c == exp_done});
                end
                if (c == exp_done) over = 1'b1;
                if (abort_pass >= 0 && pass == abort_pass && kx == 2) abort_now = 1'b1;
                if (c - s > 8000) begin
                    checks++; errors++; timed_out = 1'b1; over = 1'b1;
                    $display("FAIL %s timeout got=no_done want=done", name);
                end
            end
        end
        if (!timed_out) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b0; tail_valid = noise;
            tail_v = Wd'($urandom); tail_f = Wd'($urandom);
            @(negedge clk);
            checks++;
            if ({in_ready, busy, done, arr_en, arr_newLine, arr_t, arr_v, arr_v_alpha,
                 arr_f} !== '0) begin
                errors++;
                $display("FAIL %s idle_after got=%h want=0", name,
                         {in_ready, busy, done, arr_en, arr_newLine, arr_t, arr_v,
                          arr_v_alpha, arr_f});
            end
        end
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0; tail_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; tail_valid = 1'b1; t_len = LW'(4);
        n_pass = 8'd1; last_mask = '1; minusAlpha = '0; in_t = 2'd1;
        tail_v = '0; tail_f = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, busy, done, arr_en, arr_newLine, arr_t, arr_v, arr_v_alpha,
             arr_f} !== '0) begin
            errors++;
            $display("FAIL reset outputs got=%h want=0",
                     {in_ready, busy, done, arr_en, arr_newLine, arr_t, arr_v,
                      arr_v_alpha, arr_f});
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; tail_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset idle got=%b want=000", {in_ready, busy, done});
        end
    endtask

    task automatic test_single_pass();
        run_job("single_pass", 4, 1, 8'hFF, 16'h0000, 1'b1, 1'b0, -1);
    endtask

    task automatic test_two_pass();
        run_job("two_pass", 4, 2, 8'h07, 16'hFFFD, 1'b1, 1'b0, -1);
    endtask

    task automatic test_zero_len();
        run_job("zero_len", 0, 1, 8'hFF, 16'h0004, 1'b0, 1'b0, -1);
    endtask

    task automatic test_npass_zero();
        run_job("npass_zero", 5, 0, 8'h0F, 16'h0005, 1'b0, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            run_job("random", int'($urandom_range(24, 1)), int'($urandom_range(3, 1)),
                    ArrayN'($urandom), Wd'($urandom), 1'b0, 1'b0, -1);
        end
    endtask

    task automatic test_reset_midrun();
        run_job("reset_midrun", 6, 3, 8'h3C, 16'hFFF0, 1'b0, 1'b0, 1);
        run_job("after_reset", 5, 2, 8'hA5, 16'h0011, 1'b0, 1'b0, -1);
    endtask

    task automatic test_busy_noise();
        run_job("busy_noise", 6, 2, 8'h81, 16'h0007, 1'b0, 1'b1, -1);
        run_job("after_noise", 3, 2, 8'h00, 16'hFFFF, 1'b0, 1'b0, -1);
    endtask

    task automatic test_full_depth();
        run_job("full_depth", TDepth, 2, 8'h55, 16'h1234, 1'b0, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_two_pass();
        test_zero_len();
        test_npass_zero();
        test_random();
        test_reset_midrun();
        test_busy_noise();
        test_full_depth();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
